// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a synchronous instruction memory and
// holds a registered instruction until the consumer advances or halts.
module instruction_fetch #(
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_inc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                instr_d = mem_rdata;
                valid_d = 1'b1;
                state_d = S_READY;
            end
            S_READY: begin
                if (pc_inc) begin
                    pc_d    = jump_en ? jump_target : pc_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase
        // Halt wins over everything, including the WAIT capture.
        if (halt) begin
            state_d  = S_HALT;
            pc_d     = pc_q;
            instr_d  = instr_q;
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end
    end

    // Strobe is gated by reset so nothing is issued while reset is held.
    assign mem_rd      = (state_q == S_FETCH) && !reset;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule
